// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed 7-segment hex scanner with leading-zero blanking and blink
// Shadowed display data, prescaled digit scan, frame-based blink phase, registered outputs.
module seg_scan_ctrl #(
  parameter int NDIG         = 8,
  parameter int DIV          = 1000,
  parameter int BLINK_FRAMES = 32,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [4*NDIG-1:0] data,
  input  logic [NDIG-1:0]   dp_in,
  input  logic [NDIG-1:0]   blink_en,
  input  logic              blank_lz,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [NDIG-1:0]   an,
  output logic              frame_done
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

  logic [4*NDIG-1:0] data_sh;
  logic [NDIG-1:0]   dp_sh;
  logic [NDIG-1:0]   blink_sh;

  logic [PW-1:0] pre;
  logic [IW-1:0] idx;
  logic [FW-1:0] frm;
  logic          phase;

  logic [6:0]      seg_r, seg_n;
  logic            dp_r, dp_n;
  logic [NDIG-1:0] an_r, an_n;
  logic            frame_done_r;

  logic step, wrap;
  logic [3:0] nib;
  logic dp_sel, blink_sel, lz_sel, all_zero;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h7E;
      4'h1: hex7 = 7'h30;
      4'h2: hex7 = 7'h6D;
      4'h3: hex7 = 7'h79;
      4'h4: hex7 = 7'h33;
      4'h5: hex7 = 7'h5B;
      4'h6: hex7 = 7'h5F;
      4'h7: hex7 = 7'h70;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h7B;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h1F;
      4'hC: hex7 = 7'h4E;
      4'hD: hex7 = 7'h3D;
      4'hE: hex7 = 7'h4F;
      default: hex7 = 7'h47;
    endcase
  endfunction

  assign step = (pre == PRE_LAST);
  assign wrap = step && (idx == IDX_LAST);

  // Walk digits from the top so all_zero tracks "nibbles NDIG-1..k are zero".
  always_comb begin
    nib       = 4'd0;
    dp_sel    = 1'b0;
    blink_sel = 1'b0;
    lz_sel    = 1'b0;
    an_n      = '0;
    all_zero  = 1'b1;
    for (int k = NDIG - 1; k >= 0; k--) begin
      all_zero = all_zero & (data_sh[4*k +: 4] == 4'd0);
      if (idx == IW'(k)) begin
        nib       = data_sh[4*k +: 4];
        dp_sel    = dp_sh[k];
        blink_sel = blink_sh[k];
        lz_sel    = all_zero && (k > 0);
        an_n[k]   = 1'b1;
      end
    end
    seg_n = hex7(nib);
    dp_n  = dp_sel;
    if (blank_lz && lz_sel) begin
      seg_n = 7'd0;
    end
    if (blink_sel && phase) begin
      seg_n = 7'd0;
      dp_n  = 1'b0;
      an_n  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_sh      <= '0;
      dp_sh        <= '0;
      blink_sh     <= '0;
      pre          <= '0;
      idx          <= '0;
      frm          <= '0;
      phase        <= 1'b0;
      seg_r        <= '0;
      dp_r         <= 1'b0;
      an_r         <= '0;
      frame_done_r <= 1'b0;
    end else begin
      if (load) begin
        data_sh  <= data;
        dp_sh    <= dp_in;
        blink_sh <= blink_en;
      end
      pre <= step ? '0 : pre + PW'(1);
      if (step) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end
      frame_done_r <= wrap;
      // Blink phase advances on the same edge that raises frame_done.
      if (wrap) begin
        if (frm == FRM_LAST) begin
          frm   <= '0;
          phase <= ~phase;
        end else begin
          frm <= frm + FW'(1);
        end
      end
      seg_r <= seg_n;
      dp_r  <= dp_n;
      an_r  <= an_n;
    end
  end

  assign seg        = (ACTIVE_LOW != 0) ? ~seg_r : seg_r;
  assign dp         = (ACTIVE_LOW != 0) ? ~dp_r  : dp_r;
  assign an         = (ACTIVE_LOW != 0) ? ~an_r  : an_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - scoreboard bench for seg_scan_ctrl, both output polarities
// Expected outputs are derived from the edge count since reset and the captured display values.
module tb_seg_scan_ctrl;

  localparam int NDIG = 4;
  localparam int DIV  = 4;
  localparam int BF   = 2;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       fd;
  } exp_t;

  logic        clk, rst, load, blank_lz;
  logic [15:0] data;
  logic [3:0]  dp_in, blink_en;
  logic [6:0]  seg0, seg1;
  logic        dp0, dp1, fd0, fd1;
  logic [3:0]  an0, an1;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t q[$];
  exp_t mon_x;

  logic [15:0] m_data;
  logic [3:0]  m_dp, m_blink;
  int          n;
  logic [6:0]  hex_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  seg_scan_ctrl #(.NDIG(NDIG), .DIV(DIV), .BLINK_FRAMES(BF), .ACTIVE_LOW(0)) u_dut (
    .clk(clk), .rst(rst), .load(load), .data(data), .dp_in(dp_in), .blink_en(blink_en),
    .blank_lz(blank_lz), .seg(seg0), .dp(dp0), .an(an0), .frame_done(fd0)
  );

  seg_scan_ctrl #(.NDIG(NDIG), .DIV(DIV), .BLINK_FRAMES(BF), .ACTIVE_LOW(1)) u_dut_al (
    .clk(clk), .rst(rst), .load(load), .data(data), .dp_in(dp_in), .blink_en(blink_en),
    .blank_lz(blank_lz), .seg(seg1), .dp(dp1), .an(an1), .frame_done(fd1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Output after edge e (e=1 is the first edge after reset release).
  function automatic exp_t model(input int e, input logic blz);
    exp_t r;
    int d, ph;
    logic lead;
    d    = ((e - 1) / DIV) % NDIG;
    ph   = (((e - 1) / (DIV * NDIG)) / BF) % 2;
    lead = 1'b1;
    for (int k = d; k < NDIG; k++) begin
      if (m_data[4*k +: 4] != 4'd0) lead = 1'b0;
    end
    r.seg = (blz && d > 0 && lead) ? 7'd0 : hex_tab[m_data[4*d +: 4]];
    r.dp  = m_dp[d];
    r.an  = 4'(1 << d);
    if (m_blink[d] && ph == 1) begin
      r.seg = 7'd0;
      r.dp  = 1'b0;
      r.an  = 4'd0;
    end
    r.fd = ((e % (DIV * NDIG)) == 0);
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst && q.size() > 0) begin
      mon_x = q.pop_front();
      vectors++;
      if ({seg0, dp0, an0, fd0} !== {mon_x.seg, mon_x.dp, mon_x.an, mon_x.fd}) begin
        miscompares++;
        $display("FAIL scan_ah t=%0t got seg=%h dp=%b an=%b fd=%b want seg=%h dp=%b an=%b fd=%b",
                 $time, seg0, dp0, an0, fd0, mon_x.seg, mon_x.dp, mon_x.an, mon_x.fd);
      end
      vectors++;
      if ({seg1, dp1, an1, fd1} !== {~mon_x.seg, ~mon_x.dp, ~mon_x.an, mon_x.fd}) begin
        miscompares++;
        $display("FAIL scan_al t=%0t got seg=%h dp=%b an=%b fd=%b want seg=%h dp=%b an=%b fd=%b",
                 $time, seg1, dp1, an1, fd1, ~mon_x.seg, ~mon_x.dp, ~mon_x.an, mon_x.fd);
      end
    end
  end

  task automatic check_off(input string tag);
    vectors++;
    if ({seg0, dp0, an0, fd0} !== 12'h000) begin
      miscompares++;
      $display("FAIL %s_ah got seg=%h dp=%b an=%b fd=%b want all zero", tag, seg0, dp0, an0, fd0);
    end
    vectors++;
    if ({seg1, dp1, an1, fd1} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
      miscompares++;
      $display("FAIL %s_al got seg=%h dp=%b an=%b fd=%b want seg=7f dp=1 an=1111 fd=0",
               tag, seg1, dp1, an1, fd1);
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check_off(tag);
    q.delete();
    n       = 0;
    m_data  = '0;
    m_dp    = '0;
    m_blink = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic cycle(input logic ld, input logic [15:0] d, input logic [3:0] p,
                       input logic [3:0] b, input logic blz);
    exp_t x;
    int   e;
    load     = ld;
    data     = d;
    dp_in    = p;
    blink_en = b;
    blank_lz = blz;
    e = n + 1;
    x = model(e, blz);
    @(posedge clk);
    q.push_back(x);
    n = e;
    if (ld) begin
      m_data  = d;
      m_dp    = p;
      m_blink = b;
    end
    #1;
  endtask

  task automatic idle(input int cycles, input logic blz);
    for (int i = 0; i < cycles; i++) begin
      cycle(1'b0, 16'($urandom), 4'($urandom), 4'($urandom), blz);
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; data = '0; dp_in = '0; blink_en = '0; blank_lz = 1'b0;
    #3;
    do_reset("reset");

    idle(48, 1'b0);

    cycle(1'b1, 16'h12AF, 4'b0000, 4'b0000, 1'b0);
    idle(20, 1'b0);

    cycle(1'b1, 16'h0050, 4'b0100, 4'b0000, 1'b1);
    idle(20, 1'b1);
    cycle(1'b1, 16'h0000, 4'b0000, 4'b0000, 1'b1);
    idle(20, 1'b1);

    cycle(1'b1, 16'($urandom), 4'($urandom), 4'b0010, 1'b0);
    idle(80, 1'b0);

    for (int i = 0; i < 500; i++) begin
      cycle(($urandom_range(0, 7) == 0), 16'($urandom), 4'($urandom), 4'($urandom),
            1'($urandom));
    end

    // Asynchronous reset between clock edges, mid-digit.
    #2;
    do_reset("midreset");
    for (int i = 0; i < 100; i++) begin
      cycle(($urandom_range(0, 5) == 0), 16'($urandom), 4'($urandom), 4'($urandom),
            1'($urandom));
    end

    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 The block SHALL have parameter NDIG, default 8, giving the number of hex digits scanned (range 1..8).
REQ-002 The block SHALL have parameter DIV, default 1000, giving the clk cycles each digit is held per scan step (range >=1).
REQ-003 The block SHALL have parameter BLINK_FRAMES, default 32, giving the number of full frames per blink half-period (range >=1).
REQ-004 The block SHALL have parameter ACTIVE_LOW, default 1; when 1, seg, dp and an are inverted at the output.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, all state updates on rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 The block SHALL have port load, input, 1 bit: capture strobe for data, dp_in and blink_en.
REQ-008 The block SHALL have port data, input, 4*NDIG bits: hex value; nibble k drives digit k, with digit 0 the least significant.
REQ-009 The block SHALL have port dp_in, input, NDIG bits: decimal point request per digit.
REQ-010 The block SHALL have port blink_en, input, NDIG bits: blink enable per digit.
REQ-011 The block SHALL have port blank_lz, input, 1 bit: leading-zero blanking enable, sampled live (not captured by load).
REQ-012 The block SHALL have port seg, output, 7 bits: segments {a,b,c,d,e,f,g}, with a as MSB.
REQ-013 The block SHALL have port dp, output, 1 bit: decimal point segment.
REQ-014 The block SHALL have port an, output, NDIG bits: one-hot digit enable, with bit k selecting digit k.
REQ-015 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse at each frame end.

Function
REQ-016 Shadow registers SHALL capture data, dp_in and blink_en on any rising edge with load=1; the display SHALL use only the shadow values.
REQ-017 A prescaler SHALL count 0..DIV-1 and wrap to 0; at its wrap the digit index SHALL advance k->k+1, with NDIG-1 wrapping to 0.
REQ-018 frame_done SHALL be 1 for exactly the cycle after the index wraps NDIG-1->0, and 0 otherwise.
REQ-019 A frame counter SHALL count frame_done pulses 0..BLINK_FRAMES-1; at its wrap the blink phase bit SHALL toggle.
REQ-020 seg, dp and an SHALL be registered, each reflecting the index, shadow values and blink phase from the previous cycle (1-cycle latency).
REQ-021 Active-high hex encoding: 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=7B A=77 b=1F C=4E d=3D E=4F F=47.
REQ-022 With blank_lz=1, digit k>0 SHALL be blanked when nibbles NDIG-1..k are all zero; digit 0 SHALL never be blanked.
REQ-023 A blanked digit SHALL drive seg=0 (active-high sense), keep its an bit asserted, and keep its dp per dp_in.
REQ-024 A digit with blink_en=1 SHALL drive seg=0, dp=0 and its an bit=0 while blink phase=1; the phase SHALL be 0 after reset.
REQ-025 A load mid-scan SHALL NOT reset the prescaler, index or blink state; new values SHALL appear on the next output update.
REQ-026 When load coincides with an index advance, the new index SHALL display the newly captured values one cycle later.
REQ-027 ACTIVE_LOW SHALL apply a pure bitwise inversion to the outputs only; internal logic SHALL be polarity-independent.

Reset
REQ-028 rst=1 SHALL immediately clear the prescaler, index, frame counter, blink phase and shadow registers, independent of clk.
REQ-029 During reset, seg, dp and an SHALL be all-off (0 if ACTIVE_LOW=0, all-ones if ACTIVE_LOW=1), and frame_done SHALL be 0.
REQ-030 On the first rising edge after rst falls, the outputs SHALL show digit 0 of the shadow registers (value 0, giving seg=7E).

Verification (NDIG=4, DIV=4, BLINK_FRAMES=2, ACTIVE_LOW=0 unless stated)
REQ-031 Reset release, no load -> an=0001 for 4 cycles, then 0010, 0100, 1000 repeating, with seg=7E throughout.
REQ-032 load with data=16'h12AF -> digit0 seg=47, digit1 seg=77, digit2 seg=6D, digit3 seg=30.
REQ-033 blank_lz=1 with data=16'h0050 -> digit3 and digit2 seg=00, digit1 seg=5B, digit0 seg=7E; data=0 -> only digit0 seg=7E.
REQ-034 Free run -> frame_done pulses every 16 cycles; blink_en=0010 -> digit1 visible in frames 0-1, an[1]=0 and seg=00 in frames 2-3.
REQ-035 ACTIVE_LOW=1 with data nibble0=F -> during digit0, seg=38 and an=1110; during reset, seg=7F, dp=1 and an=1111.
REQ-036 rst asserted mid-digit, between clk edges -> outputs go all-off before the next edge, and the scan restarts at digit 0.
